output_drain_ctrl: RTL and testbench



---
 rtl/output_drain_ctrl.sv | 118 +++++++++++
 tb/tb_output_drain_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/output_drain_ctrl.sv
// Captures one batch of column results and writes it to the output buffer, one word per cycle, at ascending addresses.
// Word 0 is written in the cycle after capture. results_ready is low from the capture edge until the cycle after done.
module output_drain_ctrl #(
    parameter int NUM_COLS = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_COLS*DATA_W-1:0]   col_results,
    input  logic                         results_valid,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         results_ready,
    output logic [DATA_W-1:0]            data,
    output logic [ADDR_W-1:0]            op_buf_addr_for_store,
    output logic                         op_buffer_instr_for_storing_data,
    output logic                         busy,
    output logic                         done,
    output logic                         wrap_err
);

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t              state_q, state_nxt;
    logic [IDX_W-1:0]    k_q, k_nxt, k_inc;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   cap_q [NUM_COLS];
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                strobe_q, strobe_nxt;
    logic                done_q, done_nxt;
    logic                wrap_q, wrap_nxt;
    logic                cap_ld;
    logic [ADDR_W:0]     sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            base_q   <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                cap_q[c] <= '0;
            end
        end else begin
            state_q  <= state_nxt;
            k_q      <= k_nxt;
            data_q   <= data_nxt;
            addr_q   <= addr_nxt;
            strobe_q <= strobe_nxt;
            done_q   <= done_nxt;
            wrap_q   <= wrap_nxt;
            if (cap_ld) begin
                base_q <= base_addr;
                for (int c = 0; c < NUM_COLS; c++) begin
                    cap_q[c] <= col_results[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output registers are loaded with the word to present next, so word 0 comes straight from the inputs.
    always_comb begin
        state_nxt  = state_q;
        k_nxt      = k_q;
        data_nxt   = data_q;
        addr_nxt   = addr_q;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        wrap_nxt   = wrap_q;
        cap_ld     = 1'b0;
        k_inc      = k_q + IDX_W'(1);
        sum        = {1'b0, base_q} + (ADDR_W+1)'(k_inc);

        case (state_q)
            IDLE: begin
                if (results_valid) begin
                    cap_ld     = 1'b1;
                    state_nxt  = DRAIN;
                    k_nxt      = '0;
                    data_nxt   = col_results[DATA_W-1:0];
                    addr_nxt   = base_addr;
                    strobe_nxt = 1'b1;
                    done_nxt   = (NUM_COLS == 1);
                end
            end
            DRAIN: begin
                if (k_q == LAST_IDX) begin
                    state_nxt = IDLE;
                end else begin
                    k_nxt      = k_inc;
                    data_nxt   = cap_q[k_inc];
                    addr_nxt   = sum[ADDR_W-1:0];
                    wrap_nxt   = wrap_q | sum[ADDR_W];
                    strobe_nxt = 1'b1;
                    done_nxt   = (k_inc == LAST_IDX);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign results_ready                    = (state_q == IDLE);
    assign busy                             = (state_q == DRAIN);
    assign data                             = data_q;
    assign op_buf_addr_for_store            = addr_q;
    assign op_buffer_instr_for_storing_data = strobe_q;
    assign done                             = done_q;
    assign wrap_err                         = wrap_q;

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Directed bench for output_drain_ctrl with NUM_COLS=4, DATA_W=32, ADDR_W=4.
module tb_output_drain_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] col_results = '0;
    logic         results_valid = 1'b0;
    logic [3:0]   base_addr = '0;
    logic         results_ready;
    logic [31:0]  data;
    logic [3:0]   op_buf_addr_for_store;
    logic         op_buffer_instr_for_storing_data;
    logic         busy;
    logic         done;
    logic         wrap_err;

    int checks = 0;
    int failures = 0;

    output_drain_ctrl #(.NUM_COLS(4), .DATA_W(32), .ADDR_W(4)) dut (
        .clk                              (clk),
        .rst                              (rst),
        .col_results                      (col_results),
        .results_valid                    (results_valid),
        .base_addr                        (base_addr),
        .results_ready                    (results_ready),
        .data                             (data),
        .op_buf_addr_for_store            (op_buf_addr_for_store),
        .op_buffer_instr_for_storing_data (op_buffer_instr_for_storing_data),
        .busy                             (busy),
        .done                             (done),
        .wrap_err                         (wrap_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".strobe"}, 32'(op_buffer_instr_for_storing_data), 32'd0);
        chk({tag, ".ready"},  32'(results_ready), 32'd1);
        chk({tag, ".busy"},   32'(busy), 32'd0);
        chk({tag, ".done"},   32'(done), 32'd0);
    endtask

    task automatic write_chk(input string tag, input logic [3:0] a, input logic [31:0] d, input logic dn);
        chk({tag, ".strobe"}, 32'(op_buffer_instr_for_storing_data), 32'd1);
        chk({tag, ".addr"},   32'(op_buf_addr_for_store), 32'(a));
        chk({tag, ".data"},   data, d);
        chk({tag, ".done"},   32'(done), 32'(dn));
        chk({tag, ".busy"},   32'(busy), 32'd1);
        chk({tag, ".ready"},  32'(results_ready), 32'd0);
    endtask

    initial begin
        // Reset and idle
        tick();
        tick();
        chk("rst.wrap", 32'(wrap_err), 32'd0);
        chk("rst.data", data, 32'd0);
        chk("rst.addr", 32'(op_buf_addr_for_store), 32'd0);
        idle_chk("rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            idle_chk("idle");
            chk("idle.wrap", 32'(wrap_err), 32'd0);
        end

        // Single batch at base 2
        col_results = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        base_addr = 4'd2;
        results_valid = 1'b1;
        tick();
        results_valid = 1'b0;
        write_chk("b1w0", 4'd2, 32'h11111111, 1'b0);
        tick(); write_chk("b1w1", 4'd3, 32'h22222222, 1'b0);
        tick(); write_chk("b1w2", 4'd4, 32'h33333333, 1'b0);
        tick(); write_chk("b1w3", 4'd5, 32'h44444444, 1'b1);
        chk("b1.wrap", 32'(wrap_err), 32'd0);
        tick(); idle_chk("b1end");
        chk("b1end.data_hold", data, 32'h44444444);
        chk("b1end.addr_hold", 32'(op_buf_addr_for_store), 32'd5);

        // Wrap from base 14
        col_results = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        base_addr = 4'd14;
        results_valid = 1'b1;
        tick();
        results_valid = 1'b0;
        write_chk("wrw0", 4'd14, 32'hA0A0A0A0, 1'b0);
        chk("wrw0.wrap", 32'(wrap_err), 32'd0);
        tick(); write_chk("wrw1", 4'd15, 32'hA1A1A1A1, 1'b0);
        chk("wrw1.wrap", 32'(wrap_err), 32'd0);
        tick(); write_chk("wrw2", 4'd0, 32'hA2A2A2A2, 1'b0);
        chk("wrw2.wrap", 32'(wrap_err), 32'd1);
        tick(); write_chk("wrw3", 4'd1, 32'hA3A3A3A3, 1'b1);
        tick(); idle_chk("wrend");
        chk("wrend.wrap", 32'(wrap_err), 32'd1);
        tick();
        chk("wrend2.wrap", 32'(wrap_err), 32'd1);

        // Back-to-back with valid held high: base 0 then base 8
        col_results = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
        base_addr = 4'd0;
        results_valid = 1'b1;
        tick();
        write_chk("bbAw0", 4'd0, 32'hB0B0B0B0, 1'b0);
        col_results = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        base_addr = 4'd8;
        tick(); write_chk("bbAw1", 4'd1, 32'hB1B1B1B1, 1'b0);
        tick(); write_chk("bbAw2", 4'd2, 32'hB2B2B2B2, 1'b0);
        tick(); write_chk("bbAw3", 4'd3, 32'hB3B3B3B3, 1'b1);
        tick(); idle_chk("bbgap");
        tick(); write_chk("bbBw0", 4'd8, 32'hC0C0C0C0, 1'b0);
        results_valid = 1'b0;
        tick(); write_chk("bbBw1", 4'd9, 32'hC1C1C1C1, 1'b0);
        tick(); write_chk("bbBw2", 4'd10, 32'hC2C2C2C2, 1'b0);
        tick(); write_chk("bbBw3", 4'd11, 32'hC3C3C3C3, 1'b1);
        tick(); idle_chk("bbend");

        // Inputs changed mid-drain are ignored
        col_results = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
        base_addr = 4'd5;
        results_valid = 1'b1;
        tick();
        results_valid = 1'b0;
        write_chk("chw0", 4'd5, 32'hD0D0D0D0, 1'b0);
        col_results = {4{32'hDEADBEEF}};
        base_addr = 4'd15;
        tick(); write_chk("chw1", 4'd6, 32'hD1D1D1D1, 1'b0);
        col_results = {4{32'h0BADF00D}};
        base_addr = 4'd3;
        tick(); write_chk("chw2", 4'd7, 32'hD2D2D2D2, 1'b0);
        tick(); write_chk("chw3", 4'd8, 32'hD3D3D3D3, 1'b1);
        tick(); idle_chk("chend");

        // Reset after the 2nd write
        col_results = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
        base_addr = 4'd9;
        results_valid = 1'b1;
        tick();
        results_valid = 1'b0;
        write_chk("rmw0", 4'd9, 32'hE0E0E0E0, 1'b0);
        tick(); write_chk("rmw1", 4'd10, 32'hE1E1E1E1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_chk("rmrst");
        chk("rmrst.wrap", 32'(wrap_err), 32'd0);
        chk("rmrst.data", data, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle_chk("rmafter");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
